// File: rtl/aes_stream_pkg.sv
// Shared types and sizes for the byte-serial AES-128 stream wrapper.
package aes_stream_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BYTE_CNT_W  = 4;
  localparam int unsigned LAT_CNT_W   = 8;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLOCK_W     = BLOCK_BYTES * BYTE_W;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // True when a byte counter is on the final byte of a block.
  function automatic logic is_last_byte(input logic [BYTE_CNT_W-1:0] cnt);
    return cnt == BYTE_CNT_W'(BLOCK_BYTES - 1);
  endfunction

endpackage

// File: rtl/aes_byte_shreg.sv
// 128-bit block register with synchronous clear, parallel load and byte-wide left shift.
module aes_byte_shreg
  import aes_stream_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift,
  input  logic [BYTE_W-1:0]  shift_in,
  output logic [BLOCK_W-1:0] q
);

  // Clear wins over load, load wins over shift.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[BLOCK_W-BYTE_W-1:0], shift_in};
    end
  end

endmodule

// File: rtl/aes_byte_stream_if.sv
// Byte-serial front/back end for an AES-128 core: assembles 16 plaintext bytes,
// waits out the core latency, then streams the 16 ciphertext bytes.
module aes_byte_stream_if
  import aes_stream_pkg::*;
#(
  parameter int unsigned CORE_LATENCY = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic               key_we,
  input  logic [BYTE_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [BLOCK_W-1:0] aes_pt,
  output logic [BLOCK_W-1:0] aes_key,
  input  logic [BLOCK_W-1:0] aes_ct,
  output logic [BYTE_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy
);

  state_t                 state;
  state_t                 state_next;
  logic [BYTE_CNT_W-1:0]  in_cnt;
  logic [BYTE_CNT_W-1:0]  out_cnt;
  logic [LAT_CNT_W-1:0]   lat_cnt;
  logic [BLOCK_W-1:0]     key_reg;
  logic [BLOCK_W-1:0]     pt_q;
  logic [BLOCK_W-1:0]     ct_q;
  logic                   s_fire;
  logic                   m_fire;
  logic                   pt_shift;
  logic                   ct_load;
  logic                   ct_shift;
  logic                   lat_load;
  logic                   unused_ct_tail;

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pt_shift   = 1'b0;
    ct_load    = 1'b0;
    ct_shift   = 1'b0;
    lat_load   = 1'b0;
    case (state)
      ST_FILL: begin
        if (s_fire) begin
          pt_shift = 1'b1;
          if (is_last_byte(in_cnt)) begin
            lat_load   = 1'b1;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Capture on the last latency cycle; <= keeps a zero count from hanging.
        if (lat_cnt <= LAT_CNT_W'(1)) begin
          ct_load    = 1'b1;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_fire) begin
          ct_shift = 1'b1;
          if (is_last_byte(out_cnt)) begin
            state_next = ST_FILL;
          end
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  // Counters, key register and handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      lat_cnt <= '0;
      key_reg <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (pt_shift) begin
        in_cnt <= in_cnt + BYTE_CNT_W'(1);
      end
      if (ct_shift) begin
        out_cnt <= out_cnt + BYTE_CNT_W'(1);
      end
      if (lat_load) begin
        lat_cnt <= LAT_CNT_W'(CORE_LATENCY);
      end else if ((state == ST_WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - LAT_CNT_W'(1);
      end
      // Key may only change between blocks, never under one in flight.
      if (key_we && (state == ST_FILL) && (in_cnt == '0)) begin
        key_reg <= key_in;
      end
      s_ready <= (state_next == ST_FILL);
      m_valid <= (state_next == ST_DRAIN);
      busy    <= (state_next != ST_FILL);
    end
  end

  aes_byte_shreg u_pt_reg (
    .clk       (clk),
    .clr       (~rst_n),
    .load      (1'b0),
    .load_data ('0),
    .shift     (pt_shift),
    .shift_in  (s_data),
    .q         (pt_q)
  );

  aes_byte_shreg u_ct_reg (
    .clk       (clk),
    .clr       (~rst_n),
    .load      (ct_load),
    .load_data (aes_ct),
    .shift     (ct_shift),
    .shift_in  ('0),
    .q         (ct_q)
  );

  assign aes_pt         = pt_q;
  assign aes_key        = key_reg;
  assign m_data         = ct_q[BLOCK_W-1 -: BYTE_W];
  assign unused_ct_tail = ^ct_q[BLOCK_W-BYTE_W-1:0];

endmodule

// File: tb/tb_aes_byte_stream_if.sv
// Directed + randomized bench for aes_byte_stream_if with a behavioural AES-128 core.
module tb_aes_byte_stream_if;

  localparam int unsigned LAT   = 10;
  localparam int          LIMIT = 2000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_we;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] aes_pt;
  logic [127:0] aes_key;
  logic [127:0] aes_ct;
  logic [7:0]   m_data;
  logic         m_valid;
  logic         m_ready;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int e0     = 0;
  bit keep_sv = 1'b0;

  logic [7:0]   sbox [256];
  logic [127:0] pipe [LAT-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_byte_stream_if #(.CORE_LATENCY(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_in  (key_in),
    .key_we  (key_we),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .aes_pt  (aes_pt),
    .aes_key (aes_key),
    .aes_ct  (aes_ct),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy)
  );

  // ---------------- behavioural AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] k [16];
    logic [7:0] tmp [4];
    logic [7:0] rc = 8'h01;
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      tmp[0] = sbox[k[13]] ^ rc;
      tmp[1] = sbox[k[14]];
      tmp[2] = sbox[k[15]];
      tmp[3] = sbox[k[12]];
      for (int j = 0; j < 4; j++) k[j] = k[j] ^ tmp[j];
      for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Core stand-in: result of the plaintext held before edge E0+1 is visible before edge E0+LAT.
  always @(posedge clk) begin
    pipe[0] <= aes_enc(aes_pt, aes_key);
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign aes_ct = pipe[LAT-2];

  // ---------------- bench helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k;
    key_we = 1'b1;
    @(posedge clk); #1;
    key_we = 1'b0;
  endtask

  task automatic send(input logic [127:0] pt, input int first, input int last, input int duty,
                      input bit we_first, input logic [127:0] k);
    int idx = first;
    int guard = 0;
    logic sr;
    while (idx <= last && guard < LIMIT) begin
      s_data  = pt[127-8*idx -: 8];
      s_valid = ($urandom_range(99) < duty);
      key_we  = we_first && (idx == 0);
      if (we_first) key_in = k;
      sr = s_ready;
      @(posedge clk); #1;
      guard++;
      if (s_valid && sr) idx++;
    end
    key_we  = 1'b0;
    s_valid = keep_sv;
    if (last == 15) e0 = cyc;
    check("send_done", 128'(idx), 128'(last + 1));
  endtask

  task automatic receive(input logic [127:0] exp, input string tag, input int stop_at, input int duty);
    logic [127:0] got = '0;
    logic [7:0] md;
    logic [7:0] held = 8'h00;
    logic mv;
    bit stalled = 1'b0;
    bit seen = 1'b0;
    int n = 0;
    int guard = 0;
    while (n < stop_at && guard < LIMIT) begin
      if (m_valid && !seen) begin
        seen = 1'b1;
        check({tag, "_lat"}, 128'(cyc - e0), 128'(LAT));
      end
      if (busy) check({tag, "_sready_busy"}, 128'(s_ready), 128'(1'b0));
      if (stalled) check({tag, "_hold"}, 128'(m_data), 128'(held));
      md = m_data;
      mv = m_valid;
      m_ready = ($urandom_range(99) < duty);
      @(posedge clk); #1;
      guard++;
      if (mv && m_ready) begin
        got[127-8*n -: 8] = md;
        n++;
        stalled = 1'b0;
      end else begin
        stalled = mv;
      end
      held = md;
    end
    m_ready = 1'b0;
    check({tag, "_count"}, 128'(n), 128'(stop_at));
    if (stop_at == 16) begin
      check(tag, got, exp);
      check({tag, "_mv_end"}, 128'(m_valid), 128'(1'b0));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] k, pt, pt_g;
    int t0;
    rst_n = 1'b0; key_in = '0; key_we = 1'b0; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;

    repeat (3) @(posedge clk); #1;
    check("rst_s_ready", 128'(s_ready), 128'(1'b0));
    check("rst_m_valid", 128'(m_valid), 128'(1'b0));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_m_data", 128'(m_data), 128'(8'h00));
    check("rst_aes_pt", aes_pt, '0);
    check("rst_aes_key", aes_key, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_s_ready", 128'(s_ready), 128'(1'b1));

    // Zero key, zero plaintext.
    load_key('0);
    send('0, 0, 15, 100, 1'b0, '0);
    check("zero_pt", aes_pt, '0);
    receive(128'h66e94bd4ef8a2c3b884cfa59ca342b2e, "zero_ct", 16, 100);

    // Text vector, key load coincident with the first byte.
    send(128'h54776f204f6e65204e696e652054776f, 0, 15, 100, 1'b1,
         128'h5468617473206d79204b756e67204675);
    check("text_key", aes_key, 128'h5468617473206d79204b756e67204675);
    check("text_pt", aes_pt, 128'h54776f204f6e65204e696e652054776f);
    receive(128'h29c3505f571420f6402299b31a02d73a, "text_ct", 16, 100);

    // Random backpressure on both streams.
    pt_g = 128'h00000101030307070f0f1f1f3f3f7f7f;
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    load_key(k);
    send(pt_g, 0, 15, 50, 1'b0, '0);
    check("bp_pt", aes_pt, pt_g);
    receive(aes_enc(pt_g, k), "bp_ct", 16, 50);

    // Key pulses mid-fill and during WAIT must be ignored.
    load_key('0);
    send(pt_g, 0, 4, 100, 1'b0, '0);
    key_in = 128'h1; key_we = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    key_we = 1'b0;
    send(pt_g, 5, 15, 100, 1'b0, '0);
    key_we = 1'b1;
    @(posedge clk); #1;
    key_we = 1'b0;
    check("guard_key", aes_key, '0);
    receive(aes_enc(pt_g, '0), "guard_ct", 16, 100);

    // Reset after 7 output bytes, then a fresh block.
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    load_key(k);
    send(pt, 0, 15, 100, 1'b0, '0);
    receive(aes_enc(pt, k), "abort", 7, 100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_m_valid", 128'(m_valid), 128'(1'b0));
    check("mid_rst_s_ready", 128'(s_ready), 128'(1'b0));
    check("mid_rst_busy", 128'(busy), 128'(1'b0));
    check("mid_rst_m_data", 128'(m_data), 128'(8'h00));
    check("mid_rst_aes_pt", aes_pt, '0);
    check("mid_rst_aes_key", aes_key, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_s_ready", 128'(s_ready), 128'(1'b1));
    repeat (12) @(posedge clk);
    #1;
    check("after_rst_no_mv", 128'(m_valid), 128'(1'b0));
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    load_key(k);
    send(pt, 0, 15, 100, 1'b0, '0);
    receive(aes_enc(pt, k), "fresh_ct", 16, 100);

    // Three back-to-back blocks with both streams always ready.
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    load_key(k);
    keep_sv = 1'b1;
    t0 = cyc;
    for (int b = 0; b < 3; b++) begin
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(pt, 0, 15, 100, 1'b0, '0);
      receive(aes_enc(pt, k), "b2b_ct", 16, 100);
    end
    keep_sv = 1'b0;
    s_valid = 1'b0;
    check("b2b_cycles", 128'(cyc - t0), 128'(3 * (32 + LAT)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
